// File: rtl/prog_fetch_ctrl_if.sv
// prog_fetch_ctrl_if
// Bundles the instruction-memory bus and decoder-facing signals of the picoMIPS
// fetch controller.
//   master : fetch controller side. Drives address/ir/ir_valid/halted/retired
//            and samples I, stall, branch_abs/target, branch_rel/offset, halt_req.
//   slave  : environment side (prog memory, decoder, datapath). Mirrors master.
interface prog_fetch_ctrl_if #(
    parameter int Psize = 4,
    parameter int Isize = 20,
    parameter int Csize = 8
);
    logic [Psize-1:0] address;
    logic [Isize-1:0] I;
    logic             stall;
    logic             branch_abs;
    logic [Psize-1:0] target;
    logic             branch_rel;
    logic [Psize-1:0] offset;
    logic             halt_req;
    logic [Isize-1:0] ir;
    logic             ir_valid;
    logic             halted;
    logic [Csize-1:0] retired;

    modport master (
        output address, ir, ir_valid, halted, retired,
        input  I, stall, branch_abs, target, branch_rel, offset, halt_req
    );

    modport slave (
        input  address, ir, ir_valid, halted, retired,
        output I, stall, branch_abs, target, branch_rel, offset, halt_req
    );
endinterface

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl
// Program counter and fetch sequencer for the picoMIPS instruction memory.
// Presents the PC as the prog address, captures the returned instruction into
// an instruction register, and steps the PC by increment, absolute branch or
// relative branch. Supports pipeline stalls and a halt state that is left on a
// rising edge of a debounced board switch.
// Ports:
//   clk       : system clock, rising edge
//   n_reset   : asynchronous active-low reset
//   resume_sw : asynchronous switch level, rising edge resumes from HALT
//   bus       : prog_fetch_ctrl_if.master (address, I, stall, branch_abs,
//               target, branch_rel, offset, halt_req, ir, ir_valid, halted,
//               retired)
module prog_fetch_ctrl #(
    parameter int Psize = 4,
    parameter int Isize = 20,
    parameter int Csize = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  resume_sw,
    prog_fetch_ctrl_if.master     bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [Isize-1:0] ir_q, ir_d;
    logic             irValid_q, irValid_d;
    logic [Csize-1:0] retired_q, retired_d;

    logic             resumeMeta_q;
    logic             resumeSync_q;
    logic             resumeLast_q;
    logic             resumeRise;
    logic [Csize-1:0] retiredInc;

    // Only a fresh press counts: a switch already held high when HALT is
    // entered produces no rise until it is released and pressed again.
    assign resumeRise = resumeSync_q & ~resumeLast_q;

    // Saturating retired-instruction count.
    assign retiredInc = (retired_q == {Csize{1'b1}}) ? retired_q : retired_q + Csize'(1);

    assign bus.address  = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = irValid_q;
    assign bus.retired  = retired_q;
    assign bus.halted   = (state_q == HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        irValid_d = irValid_q;
        retired_d = retired_q;

        case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    ir_d      = bus.I;
                    irValid_d = 1'b1;
                    retired_d = retiredInc;
                    state_d   = HALT;
                end else if (!bus.stall) begin
                    ir_d      = bus.I;
                    irValid_d = 1'b1;
                    retired_d = retiredInc;
                    if (bus.branch_abs) begin
                        pc_d = bus.target;
                    end else if (bus.branch_rel) begin
                        // Psize-bit modular add equals adding the
                        // sign-extended offset and truncating.
                        pc_d = pc_q + bus.offset;
                    end else begin
                        pc_d = pc_q + Psize'(1);
                    end
                end
            end
            HALT: begin
                irValid_d = 1'b0;
                if (resumeRise) begin
                    state_d = RUN;
                    pc_d    = pc_q + Psize'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= RUN;
            pc_q         <= '0;
            ir_q         <= '0;
            irValid_q    <= 1'b0;
            retired_q    <= '0;
            resumeMeta_q <= 1'b0;
            resumeSync_q <= 1'b0;
            resumeLast_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            irValid_q    <= irValid_d;
            retired_q    <= retired_d;
            resumeMeta_q <= resume_sw;
            resumeSync_q <= resumeMeta_q;
            resumeLast_q <= resumeSync_q;
        end
    end

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// tb_prog_fetch_ctrl
// Self-checking bench for prog_fetch_ctrl. A random 16-word program sits
// behind the address bus; a behavioural model tracks the expected PC, IR,
// valid flag, retired count and halt status in plain integer arithmetic.
module tb_prog_fetch_ctrl;

    logic clk       = 1'b0;
    logic n_reset   = 1'b1;
    logic resume_sw = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [19:0] prog [16];

    int          mPc;
    int          mRet;
    logic [19:0] mIr;
    logic        mValid;
    bit          mHalt;

    prog_fetch_ctrl_if #(.Psize(4), .Isize(20), .Csize(8)) bus ();

    prog_fetch_ctrl #(.Psize(4), .Isize(20), .Csize(8)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .resume_sw (resume_sw),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.I = prog[bus.address];

    // Return all control inputs to idle.
    task automatic clearInputs();
        bus.stall      = 1'b0;
        bus.branch_abs = 1'b0;
        bus.branch_rel = 1'b0;
        bus.halt_req   = 1'b0;
        bus.target     = 4'd0;
        bus.offset     = 4'd0;
    endtask

    task automatic modelReset();
        mPc    = 0;
        mRet   = 0;
        mIr    = 20'd0;
        mValid = 1'b0;
        mHalt  = 1'b0;
    endtask

    task automatic modelFetch();
        mIr    = prog[mPc];
        mValid = 1'b1;
        if (mRet < 255) mRet = mRet + 1;
    endtask

    // One clock of intended behaviour, from the current inputs.
    task automatic modelStep();
        int off;
        if (mHalt) begin
            mValid = 1'b0;
            return;
        end
        if (bus.halt_req) begin
            modelFetch();
            mHalt = 1'b1;
        end else if (!bus.stall) begin
            modelFetch();
            if (bus.branch_abs) begin
                mPc = int'(bus.target);
            end else if (bus.branch_rel) begin
                off = bus.offset[3] ? int'(bus.offset) - 16 : int'(bus.offset);
                mPc = (mPc + off + 16) % 16;
            end else begin
                mPc = (mPc + 1) % 16;
            end
        end
    endtask

    // Advance the model and the DUT by one clock, leaving time at posedge+1.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Place the PC at a given address via an absolute branch.
    task automatic jumpTo(input int dest);
        clearInputs();
        bus.branch_abs = 1'b1;
        bus.target     = 4'(dest);
        applyStimulus();
        clearInputs();
    endtask

    task automatic test_reset();
        clearInputs();
        #1 n_reset = 1'b0;
        #10;
        modelReset();
        checks++;
        if (bus.address !== 4'd0) begin errors++; $display("[TB] FAIL reset_address got %h expected 0", bus.address); end
        checks++;
        if (bus.ir !== 20'd0) begin errors++; $display("[TB] FAIL reset_ir got %h expected 0", bus.ir); end
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_valid got %b expected 0", bus.ir_valid); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b expected 0", bus.halted); end
        checks++;
        if (bus.retired !== 8'd0) begin errors++; $display("[TB] FAIL reset_retired got %0d expected 0", bus.retired); end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_free_run();
        clearInputs();
        for (int i = 1; i <= 16; i++) begin
            applyStimulus();
            checks++;
            if (bus.address !== 4'(i % 16)) begin errors++; $display("[TB] FAIL freerun_address[%0d] got %h expected %h", i, bus.address, 4'(i % 16)); end
            checks++;
            if (bus.ir !== prog[i-1]) begin errors++; $display("[TB] FAIL freerun_ir[%0d] got %h expected %h", i, bus.ir, prog[i-1]); end
            checks++;
            if (bus.ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL freerun_ir_valid[%0d] got %b expected 1", i, bus.ir_valid); end
        end
        checks++;
        if (bus.retired !== 8'd16) begin errors++; $display("[TB] FAIL freerun_retired got %0d expected 16", bus.retired); end
    endtask

    task automatic test_branches();
        jumpTo(5);
        bus.branch_abs = 1'b1;
        bus.target     = 4'd12;
        applyStimulus();
        checks++;
        if (bus.address !== 4'd12) begin errors++; $display("[TB] FAIL abs_address got %h expected c", bus.address); end
        checks++;
        if (bus.ir !== prog[5]) begin errors++; $display("[TB] FAIL abs_ir got %h expected %h", bus.ir, prog[5]); end

        jumpTo(3);
        bus.branch_rel = 1'b1;
        bus.offset     = 4'b1110;
        applyStimulus();
        checks++;
        if (bus.address !== 4'd1) begin errors++; $display("[TB] FAIL rel_negative_address got %h expected 1", bus.address); end
        checks++;
        if (bus.ir !== prog[3]) begin errors++; $display("[TB] FAIL rel_negative_ir got %h expected %h", bus.ir, prog[3]); end

        jumpTo(14);
        bus.branch_rel = 1'b1;
        bus.offset     = 4'b0011;
        applyStimulus();
        checks++;
        if (bus.address !== 4'd1) begin errors++; $display("[TB] FAIL rel_wrap_address got %h expected 1", bus.address); end

        jumpTo(2);
        bus.branch_abs = 1'b1;
        bus.target     = 4'd8;
        bus.branch_rel = 1'b1;
        bus.offset     = 4'd1;
        applyStimulus();
        checks++;
        if (bus.address !== 4'd8) begin errors++; $display("[TB] FAIL abs_over_rel_address got %h expected 8", bus.address); end
        clearInputs();
    endtask

    task automatic test_stall();
        logic [19:0] irHeld;
        logic [7:0]  retHeld;
        jumpTo(7);
        irHeld  = mIr;
        retHeld = 8'(mRet);
        bus.stall      = 1'b1;
        bus.branch_abs = 1'b1;
        bus.target     = 4'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checks++;
            if (bus.address !== 4'd7) begin errors++; $display("[TB] FAIL stall_address[%0d] got %h expected 7", i, bus.address); end
            checks++;
            if (bus.ir !== irHeld) begin errors++; $display("[TB] FAIL stall_ir[%0d] got %h expected %h", i, bus.ir, irHeld); end
            checks++;
            if (bus.retired !== retHeld) begin errors++; $display("[TB] FAIL stall_retired[%0d] got %0d expected %0d", i, bus.retired, retHeld); end
        end
        clearInputs();
        applyStimulus();
        checks++;
        if (bus.address !== 4'd8) begin errors++; $display("[TB] FAIL post_stall_address got %h expected 8", bus.address); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.branch_abs = ($urandom_range(0, 4) == 0);
            bus.branch_rel = ($urandom_range(0, 3) == 0);
            bus.target     = 4'($urandom);
            bus.offset     = 4'($urandom);
            bus.halt_req   = 1'b0;
            applyStimulus();
            checks++;
            if ({bus.address, bus.ir, bus.ir_valid, bus.halted, bus.retired} !==
                {4'(mPc), mIr, mValid, 1'b0, 8'(mRet)}) begin
                errors++;
                $display("[TB] FAIL random[%0d] got addr=%h ir=%h v=%b h=%b ret=%0d expected addr=%h ir=%h v=%b h=0 ret=%0d",
                         i, bus.address, bus.ir, bus.ir_valid, bus.halted, bus.retired, 4'(mPc), mIr, mValid, mRet);
            end
        end
        clearInputs();
    endtask

    task automatic test_halt_resume();
        int waited;
        resume_sw = 1'b0;
        jumpTo(9);
        bus.halt_req = 1'b1;
        applyStimulus();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_entry got %b expected 1", bus.halted); end
        checks++;
        if (bus.address !== 4'd9) begin errors++; $display("[TB] FAIL halt_address got %h expected 9", bus.address); end
        checks++;
        if (bus.ir !== prog[9] || bus.ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_ir got %h/%b expected %h/1", bus.ir, bus.ir_valid, prog[9]); end

        // Inputs that must be ignored while halted.
        bus.branch_abs = 1'b1;
        bus.target     = 4'd3;
        applyStimulus();
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_ir_valid got %b expected 0", bus.ir_valid); end
        checks++;
        if (bus.address !== 4'd9 || bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_hold got addr=%h h=%b expected addr=9 h=1", bus.address, bus.halted); end
        clearInputs();

        resume_sw = 1'b1;
        waited = 0;
        while (bus.halted === 1'b1 && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL resume_timeout halted=%b expected 0 within 4 cycles", bus.halted); end
        checks++;
        if (bus.address !== 4'd10) begin errors++; $display("[TB] FAIL resume_address got %h expected a", bus.address); end
        mPc   = 10;
        mHalt = 1'b0;

        // Second halt with the switch still held high.
        applyStimulus();
        bus.halt_req = 1'b1;
        applyStimulus();
        clearInputs();
        for (int i = 0; i < 6; i++) applyStimulus();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL held_switch_halted got %b expected 1", bus.halted); end
        resume_sw = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        checks++;
        if (bus.halted !== 1'b1 || bus.address !== 4'd11) begin errors++; $display("[TB] FAIL release_halted got h=%b addr=%h expected h=1 addr=b", bus.halted, bus.address); end
        resume_sw = 1'b1;
        waited = 0;
        while (bus.halted === 1'b1 && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (bus.halted !== 1'b0 || bus.address !== 4'd12) begin errors++; $display("[TB] FAIL repress_resume got h=%b addr=%h expected h=0 addr=c", bus.halted, bus.address); end
        checks++;
        if (bus.ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL repress_ir_valid got %b expected 0", bus.ir_valid); end
        mPc   = 12;
        mHalt = 1'b0;
        resume_sw = 1'b0;
    endtask

    task automatic test_saturation();
        clearInputs();
        n_reset = 1'b0;
        #2 n_reset = 1'b1;
        modelReset();
        for (int i = 0; i < 254; i++) applyStimulus();
        checks++;
        if (bus.retired !== 8'd254) begin errors++; $display("[TB] FAIL sat_preload got %0d expected 254", bus.retired); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checks++;
            if (bus.retired !== 8'd255) begin errors++; $display("[TB] FAIL sat_retired[%0d] got %0d expected 255", i, bus.retired); end
        end
    endtask

    task automatic test_async_reset();
        jumpTo(6);
        bus.halt_req = 1'b1;
        applyStimulus();
        clearInputs();
        applyStimulus();
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if (bus.address !== 4'd0 || bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_state got addr=%h h=%b expected addr=0 h=0", bus.address, bus.halted); end
        checks++;
        if (bus.ir !== 20'd0 || bus.ir_valid !== 1'b0 || bus.retired !== 8'd0) begin
            errors++; $display("[TB] FAIL async_reset_regs got ir=%h v=%b ret=%0d expected 0/0/0", bus.ir, bus.ir_valid, bus.retired);
        end
        modelReset();
        @(negedge clk);
        n_reset = 1'b1;
        applyStimulus();
        checks++;
        if (bus.address !== 4'd1 || bus.ir !== prog[0]) begin errors++; $display("[TB] FAIL post_reset_fetch got addr=%h ir=%h expected addr=1 ir=%h", bus.address, bus.ir, prog[0]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 20'($urandom_range(1, 20'hFFFFF));
        clearInputs();
        modelReset();
        test_reset();
        test_free_run();
        test_branches();
        test_stall();
        test_random();
        test_halt_resume();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
